// File: rtl/stat_bist_pkg.sv
// -----------------------------------------------------------------------------
// stat_bist_pkg
// Shared definitions for the statistical BIST controller:
//   - bist_state_e : controller states (IDLE, LOAD, RUN, DONE)
//   - LFSR_TAPS    : feedback taps for x^32 + x^22 + x^2 + x + 1 (bits 31,21,1,0)
//   - lfsr_step()  : one shift of the pattern LFSR / MISR without the XOR input
// -----------------------------------------------------------------------------
package stat_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Shift left by one; the new LSB is the parity of the tapped bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stat_bist_if.sv
// -----------------------------------------------------------------------------
// stat_bist_if
// Bundles the harness-facing and CUT-facing signals of stat_bist_controller.
//   start      : run request (harness -> controller)
//   golden_sig : expected signature (harness -> controller)
//   cut_out    : CUT response (CUT -> controller)
//   cut_in     : pattern driving the CUT inputs (controller -> CUT)
//   busy       : high while loading / running
//   done       : one-cycle end-of-run pulse
//   pass       : result of the last run
//   signature  : MISR contents
//   abort      : only when STAT_BIST_ABORT_EN is defined; cuts a run short
// Modports: master = harness/CUT side, slave = controller side.
// -----------------------------------------------------------------------------
interface stat_bist_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] golden_sig;
    logic [WIDTH-1:0] cut_out;
    logic [WIDTH-1:0] cut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;

`ifdef STAT_BIST_ABORT_EN
    logic             abort;

    modport master (
        output start, golden_sig, cut_out, abort,
        input  cut_in, busy, done, pass, signature
    );

    modport slave (
        input  start, golden_sig, cut_out, abort,
        output cut_in, busy, done, pass, signature
    );
`else
    modport master (
        output start, golden_sig, cut_out,
        input  cut_in, busy, done, pass, signature
    );

    modport slave (
        input  start, golden_sig, cut_out,
        output cut_in, busy, done, pass, signature
    );
`endif

endinterface

// File: rtl/stat_lfsr_step.sv
// -----------------------------------------------------------------------------
// stat_lfsr_step
// Combinational next-state for the shared LFSR/MISR structure:
//   state_out = lfsr_step(state_in) ^ xor_in
// With xor_in tied to zero this is a plain pattern LFSR; with xor_in fed by
// the CUT outputs it becomes the signature compactor (MISR).
// Ports:
//   state_in  in  WIDTH  current register value
//   xor_in    in  WIDTH  value folded into the shifted state
//   state_out out WIDTH  next register value
// WIDTH must be 32 to match the tap polynomial in stat_bist_pkg.
// -----------------------------------------------------------------------------
module stat_lfsr_step
    import stat_bist_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] state_in,
    input  logic [WIDTH-1:0] xor_in,
    output logic [WIDTH-1:0] state_out
);

    assign state_out = lfsr_step(state_in) ^ xor_in;

endmodule

// File: rtl/stat_bist_controller.sv
// -----------------------------------------------------------------------------
// stat_bist_controller
// BIST sequencer for one combinational CUT: an LFSR drives cut_in, a MISR
// compacts cut_out, and the final signature is compared with golden_sig.
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   asynchronous active-high reset
//   bus       stat_bist_if.slave (start, golden_sig, cut_out, cut_in, busy,
//             done, pass, signature, and abort when enabled)
// Parameters: WIDTH (32 only), PATTERN_COUNT (1..65535), SEED (non-zero),
//             CNT_W (pattern counter width).
// Optional feature macro: STAT_BIST_ABORT_EN adds bus.abort, which ends a run
// from LOAD or RUN by jumping to DONE with pass forced low.
// -----------------------------------------------------------------------------
module stat_bist_controller
    import stat_bist_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter int               PATTERN_COUNT = 1024,
    parameter logic [WIDTH-1:0] SEED          = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int               CNT_W         = 16
) (
    input logic       clk,
    input logic       rst,
    stat_bist_if.slave bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PATTERN_COUNT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] next_pattern;
    logic [WIDTH-1:0] next_sig;
    logic             pass_q;
    logic             aborted;
    logic             abort_req;

`ifdef STAT_BIST_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    stat_lfsr_step #(.WIDTH(WIDTH)) u_pattern_gen (
        .state_in  (pattern),
        .xor_in    ({WIDTH{1'b0}}),
        .state_out (next_pattern)
    );

    stat_lfsr_step #(.WIDTH(WIDTH)) u_misr (
        .state_in  (sig),
        .xor_in    (bus.cut_out),
        .state_out (next_sig)
    );

    // Sequencer. An abort wins over the normal work of the cycle, so the
    // signature stays exactly as it was after the last absorbed pattern.
    // 'aborted' remembers why DONE was entered so the compare can be skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            pattern <= '0;
            sig     <= '0;
            pass_q  <= 1'b0;
            aborted <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_LOAD;
                        aborted <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort_req) begin
                        state   <= ST_DONE;
                        aborted <= 1'b1;
                    end else begin
                        pattern <= SEED;
                        sig     <= '0;
                        count   <= '0;
                        pass_q  <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_req) begin
                        state   <= ST_DONE;
                        aborted <= 1'b1;
                    end else begin
                        sig     <= next_sig;
                        pattern <= next_pattern;
                        count   <= count + 1'b1;
                        if (count == LAST_COUNT) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    pass_q <= aborted ? 1'b0 : (sig == bus.golden_sig);
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cut_in    = pattern;
    assign bus.signature = sig;
    assign bus.busy      = (state == ST_LOAD) || (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);
    assign bus.pass      = pass_q;

endmodule
